// File: rtl/aes_key_mem.sv
// AES-128 key expansion and round-key store: expands the cipher key into
// NUM_ROUNDS+1 round keys (one per clock) and serves them by round index.
module aes_key_mem #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [3:0]       round_i,
  output logic [KEY_W-1:0] round_key_o,
  output logic             ready_o
);

  // state | meaning
  // IDLE  | schedule valid (or reset), waiting for init_i
  // INIT  | store the cipher key as round key 0
  // GEN   | derive one round key per cycle from the previous one
  typedef enum logic [1:0] {IDLE, INIT, GEN} state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_e           state_q;
  logic [KEY_W-1:0] key_mem_q [NUM_ROUNDS+1];
  logic [KEY_W-1:0] key_reg_q;
  logic [KEY_W-1:0] prev_key_q;
  logic [KEY_W-1:0] next_key_d;
  logic [3:0]       round_ctr_q;
  logic [7:0]       rcon_q;
  logic [7:0]       rcon_d;
  logic             ready_q;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w, sub_w, t_w;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = prev_key_q[127:96];
  assign w1 = prev_key_q[95:64];
  assign w2 = prev_key_q[63:32];
  assign w3 = prev_key_q[31:0];

  assign rot_w = {w3[23:0], w3[31:24]};
  assign sub_w = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]};
  assign t_w   = sub_w ^ {rcon_q, 24'h0};

  assign n0 = w0 ^ t_w;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key_d = {n0, n1, n2, n3};
  assign rcon_d     = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      key_reg_q   <= '0;
      prev_key_q  <= '0;
      round_ctr_q <= '0;
      rcon_q      <= 8'h01;
      for (int i = 0; i <= NUM_ROUNDS; i++) key_mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (init_i) begin
            key_reg_q <= key_i;
            ready_q   <= 1'b0;
            state_q   <= INIT;
          end
        end
        INIT: begin
          key_mem_q[0] <= key_reg_q;
          prev_key_q   <= key_reg_q;
          round_ctr_q  <= 4'd1;
          rcon_q       <= 8'h01;
          state_q      <= GEN;
        end
        GEN: begin
          key_mem_q[round_ctr_q] <= next_key_d;
          prev_key_q             <= next_key_d;
          rcon_q                 <= rcon_d;
          if (round_ctr_q == 4'(NUM_ROUNDS)) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            round_ctr_q <= round_ctr_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Indices past the last round read as zero rather than aliasing.
  always_comb begin
    round_key_o = '0;
    if (32'(round_i) <= NUM_ROUNDS) round_key_o = key_mem_q[round_i];
  end

  assign ready_o = ready_q;

endmodule

// File: tb/tb_aes_key_mem.sv
// Scoreboard bench for aes_key_mem: stimulus pushes expected schedules built by a
// GF(2^8) reference model; a monitor checks ready timing and sweeps round_key_o.
module tb_aes_key_mem;

  typedef logic [0:10][127:0] sched_t;
  typedef struct {
    bit     is_reset;
    bit     sweep;
    sched_t keys;
  } item_t;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         init_i = 1'b0;
  logic [127:0] key_i = '0;
  logic [3:0]   round_i = '0;
  logic [127:0] round_key_o;
  logic         ready_o;

  int    checks = 0;
  int    failures = 0;
  item_t sb[$];
  int    push_cnt = 0;
  int    done_cnt = 0;
  bit    stim_done = 1'b0;

  aes_key_mem dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .init_i     (init_i),
    .key_i      (key_i),
    .round_i    (round_i),
    .round_key_o(round_key_o),
    .ready_o    (ready_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic sched_t expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc = 8'h01;
    sched_t      s;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {ref_sbox(temp[31:24]), ref_sbox(temp[23:16]), ref_sbox(temp[15:8]), ref_sbox(temp[7:0])};
        temp = temp ^ {rc, 24'h0};
        rc   = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // ---------------- checking ----------------
  task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic sweep(input sched_t k, input bit zero, input string nm);
    logic [127:0] exp;
    for (int r = 0; r < 16; r++) begin
      round_i = 4'(r);
      #1;
      exp = '0;
      if (!zero && r <= 10) exp = k[r];
      chk128($sformatf("%s[%0d]", nm, r), round_key_o, exp);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit     prev_ready;
    bit     rst_seen;
    bit     stuck;
    int     low_cnt;
    item_t  it;
    sched_t m;
    prev_ready = 1'b1;
    rst_seen   = 1'b1;
    stuck      = 1'b0;
    low_cnt    = 0;

    m = expand(FIPS_KEY);
    chk128("model_fips_r1", m[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk128("model_fips_r10", m[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    m = expand(128'h0);
    chk128("model_zero_r1", m[1], 128'h62636363626363636263636362636363);
    chk128("model_zero_r10", m[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    forever begin
      @(negedge clk);
      if (stim_done) begin
        chk_int("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      if (rst_i) begin
        if (!rst_seen) begin
          rst_seen = 1'b1;
          if (sb.size() == 0 || !sb[0].is_reset) begin
            checks++;
            failures++;
            $display("FAIL unexpected_reset actual=reset required=no_reset");
          end else begin
            it = sb.pop_front();
            chk_int("rst_ready", int'(ready_o), 1);
            sweep(it.keys, 1'b1, "rst_key");
            done_cnt++;
          end
        end
        low_cnt    = 0;
        prev_ready = 1'b1;
        stuck      = 1'b0;
      end else begin
        rst_seen = 1'b0;
        if (!ready_o) begin
          low_cnt++;
          if (low_cnt > 40 && !stuck) begin
            stuck = 1'b1;
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=%0d required=11", low_cnt);
          end
        end else if (!prev_ready) begin
          if (sb.size() == 0 || sb[0].is_reset) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ready actual=rise required=none");
          end else begin
            it = sb.pop_front();
            chk_int("ready_low_cycles", low_cnt, 11);
            if (it.sweep) sweep(it.keys, 1'b0, "round_key");
            done_cnt++;
          end
          low_cnt = 0;
          stuck   = 1'b0;
        end
        prev_ready = ready_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_mon();
    int n = 0;
    while (done_cnt != push_cnt && n < 600) begin
      @(posedge clk);
      n++;
    end
  endtask

  task automatic push_exp(input logic [127:0] k, input bit sw);
    item_t it;
    it.is_reset = 1'b0;
    it.sweep    = sw;
    it.keys     = expand(k);
    sb.push_back(it);
    push_cnt++;
  endtask

  task automatic push_rst();
    item_t it;
    it.is_reset = 1'b1;
    it.sweep    = 1'b1;
    it.keys     = '0;
    sb.push_back(it);
    push_cnt++;
  endtask

  task automatic do_init(input logic [127:0] k);
    @(posedge clk);
    #1;
    key_i  = k;
    init_i = 1'b1;
    push_exp(k, 1'b1);
    @(posedge clk);
    #1;
    init_i = 1'b0;
    wait_mon();
  endtask

  function automatic logic [127:0] rnd_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] ka, kb;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    do_init(FIPS_KEY);

    // asynchronous reset mid-cycle clears the populated schedule
    @(posedge clk);
    #3;
    push_rst();
    rst_i = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst_i = 1'b0;
    wait_mon();

    do_init(128'h0);

    // init while busy is ignored
    ka = rnd_key();
    kb = rnd_key();
    @(posedge clk);
    #1;
    key_i  = ka;
    init_i = 1'b1;
    push_exp(ka, 1'b1);
    @(posedge clk);
    #1 init_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    key_i  = kb;
    init_i = 1'b1;
    @(posedge clk);
    #1 init_i = 1'b0;
    wait_mon();

    // reset at E+6 aborts, then a clean FIPS expansion
    @(posedge clk);
    #1;
    key_i  = rnd_key();
    init_i = 1'b1;
    @(posedge clk);
    #1 init_i = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    push_rst();
    rst_i = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst_i = 1'b0;
    wait_mon();
    do_init(FIPS_KEY);

    // init held across ready rising: second acceptance one cycle later
    ka = rnd_key();
    kb = rnd_key();
    @(posedge clk);
    #1;
    key_i  = ka;
    init_i = 1'b1;
    push_exp(ka, 1'b0);
    push_exp(kb, 1'b1);
    @(posedge clk);
    #1 key_i = kb;
    repeat (12) @(posedge clk);
    #1 init_i = 1'b0;
    wait_mon();

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      do_init(rnd_key());
    end

    repeat (2) @(posedge clk);
    stim_done = 1'b1;
  end

endmodule
